playfield_fetch: RTL and testbench

Playfield tile fetcher and pixel serializer that reads the 1K playfield video RAM through its read-only port b (`address_b`/`q_b`) and produces one playfield pixel per clock. Each tile row costs one VRAM read for an 8-bit tile code and one character-ROM read for the 8-pixel bitmap row. Bitmaps are double-buffered so that pixels leave without gaps. It sits between the playfield VRAM and the video mixer, driven by the shared horizontal and vertical counters.

---
 rtl/playfield_fetch.sv | 151 +++++++++++++++
 tb/tb_playfield_fetch.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/playfield_fetch.sv
// Playfield tile fetcher: VRAM code read, char-ROM bitmap read, double-buffered serializer.
// Optional PF_INVERT_EN: tile code bit 7 inverts that tile's pixels.
module playfield_fetch #(
    parameter logic [8:0] PREFETCH_H = 9'd504
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [8:0] hcount,
    input  logic [7:0] vcount,
    input  logic       vblank,
    output logic [9:0] vram_addr,
    input  logic [7:0] vram_q,
    output logic [8:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       pix_out,
    output logic       pix_valid,
    output logic       fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_RAM_RD, S_CODE, S_ROM_RD, S_LATCH, S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic       abort;
    logic       fetch_start, take_code, take_bitmap;

    logic [2:0] phase;
    logic       active;
    logic       win_line, win_pre, fetch_open;
    logic [7:0] next_v;
    logic [4:0] fetch_row, fetch_col;
    logic [2:0] fetch_prow;

    logic [9:0] vram_addr_q;
    logic [8:0] rom_addr_q;
    logic [2:0] prow_q;
    logic [7:0] pending_q;
    logic [7:0] shreg_q;
    logic       pix_q, valid_q, err_q;
    logic       pix_bit;

    assign phase      = hcount[2:0];
    assign active     = !hcount[8] && !vblank;
    assign win_line   = (hcount < 9'd248);
    assign win_pre    = (hcount[8:3] == PREFETCH_H[8:3]);
    assign fetch_open = !vblank && (win_line || win_pre);
    assign next_v     = vcount + 8'd1;

    // Line-window fetches target the next column; the prefetch targets column 0 of the next line.
    always_comb begin
        if (win_line) begin
            fetch_row  = vcount[7:3];
            fetch_col  = hcount[7:3] + 5'd1;
            fetch_prow = vcount[2:0];
        end else begin
            fetch_row  = next_v[7:3];
            fetch_col  = 5'd0;
            fetch_prow = next_v[2:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Every busy state is tied to one phase (DONE spans 5..7); any other phase aborts.
    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        case (state_q)
            S_IDLE:   if (phase == 3'd0 && fetch_open) state_d = S_RAM_RD;
            S_RAM_RD: if (phase == 3'd1) state_d = S_CODE;   else abort = 1'b1;
            S_CODE:   if (phase == 3'd2) state_d = S_ROM_RD; else abort = 1'b1;
            S_ROM_RD: if (phase == 3'd3) state_d = S_LATCH;  else abort = 1'b1;
            S_LATCH:  if (phase == 3'd4) state_d = S_DONE;   else abort = 1'b1;
            S_DONE: begin
                if (phase == 3'd7)                         state_d = S_IDLE;
                else if (phase != 3'd5 && phase != 3'd6)   abort   = 1'b1;
            end
            default:  state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    always_comb begin
        fetch_start = (state_q == S_IDLE) && (state_d == S_RAM_RD);
        take_code   = (state_q == S_CODE)  && !abort;
        take_bitmap = (state_q == S_LATCH) && !abort;
    end

`ifdef PF_INVERT_EN
    logic code_inv_q, pend_inv_q, shreg_inv_q;
    logic unused_code;
    assign unused_code = vram_q[6];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            code_inv_q  <= 1'b0;
            pend_inv_q  <= 1'b0;
            shreg_inv_q <= 1'b0;
        end else begin
            if (take_code)   code_inv_q <= vram_q[7];
            if (abort)       pend_inv_q <= 1'b0;
            else if (take_bitmap) pend_inv_q <= code_inv_q;
            if (phase == 3'd0 && active) shreg_inv_q <= pend_inv_q;
        end
    end

    assign pix_bit = (phase == 3'd0 && active) ? (pending_q[7] ^ pend_inv_q)
                                               : (shreg_q[7] ^ shreg_inv_q);
`else
    logic unused_code;
    assign unused_code = ^vram_q[7:6];
    assign pix_bit = (phase == 3'd0 && active) ? pending_q[7] : shreg_q[7];
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vram_addr_q <= '0;
            rom_addr_q  <= '0;
            prow_q      <= '0;
            pending_q   <= '0;
            shreg_q     <= '0;
            pix_q       <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (fetch_start) begin
                vram_addr_q <= {fetch_row, fetch_col};
                prow_q      <= fetch_prow;
            end
            if (take_code) rom_addr_q <= {vram_q[5:0], prow_q};
            if (abort)            pending_q <= '0;
            else if (take_bitmap) pending_q <= rom_data;
            if (phase == 3'd0 && active) shreg_q <= {pending_q[6:0], 1'b0};
            else                         shreg_q <= {shreg_q[6:0], 1'b0};
            pix_q   <= active ? pix_bit : 1'b0;
            valid_q <= active;
            err_q   <= abort;
        end
    end

    assign vram_addr = vram_addr_q;
    assign rom_addr  = rom_addr_q;
    assign pix_out   = pix_q;
    assign pix_valid = valid_q;
    assign fetch_err = err_q;

endmodule

// File: tb/tb_playfield_fetch.sv
// Bench for playfield_fetch: behavioural VRAM/ROM plus a per-pixel screen model.
module tb_playfield_fetch;

    logic       clock = 1'b0;
    logic       reset;
    logic [8:0] hcount;
    logic [7:0] vcount;
    logic       vblank;
    logic [9:0] vram_addr;
    logic [7:0] vram_q;
    logic [8:0] rom_addr;
    logic [7:0] rom_data;
    logic       pix_out, pix_valid, fetch_err;

    logic [7:0] vram_mem [0:1023];
    logic [7:0] rom_mem  [0:511];

    int vectors = 0;
    int miscompares = 0;

    playfield_fetch dut (
        .clock(clock), .reset(reset), .hcount(hcount), .vcount(vcount),
        .vblank(vblank), .vram_addr(vram_addr), .vram_q(vram_q),
        .rom_addr(rom_addr), .rom_data(rom_data), .pix_out(pix_out),
        .pix_valid(pix_valid), .fetch_err(fetch_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        vram_q   <= vram_mem[vram_addr];
        rom_data <= rom_mem[rom_addr];
    end

    // What screen pixel (v, x) should be, straight from the tile map and bitmap.
    function automatic logic exp_pix(input int v, input int x);
        logic [7:0] code, bits;
        logic [9:0] va;
        logic [8:0] ra;
        logic       r;
        va   = {v[7:3], x[7:3]};
        code = vram_mem[va];
        ra   = {code[5:0], v[2:0]};
        bits = rom_mem[ra];
        r    = bits[7 - (x % 8)];
`ifdef PF_INVERT_EN
        r = r ^ code[7];
`endif
        return r;
    endfunction

    task automatic tick(input int h, input int v, input logic vb);
        hcount = h[8:0];
        vcount = v[7:0];
        vblank = vb;
        @(posedge clock);
        #1;
    endtask

    task automatic warm_line(input int v);
        for (int h = 0; h < 512; h++) tick(h, v, 1'b0);
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < 1024; i++) vram_mem[i] = $urandom_range(0, 255);
        for (int i = 0; i < 512; i++)  rom_mem[i]  = $urandom_range(0, 255);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick(i, 0, 1'b0);
        vectors++; if (vram_addr !== 10'd0) begin miscompares++; $display("FAIL reset_vram_addr got=%0h want=0", vram_addr); end
        vectors++; if (rom_addr !== 9'd0)   begin miscompares++; $display("FAIL reset_rom_addr got=%0h want=0", rom_addr); end
        vectors++; if (pix_out !== 1'b0)    begin miscompares++; $display("FAIL reset_pix_out got=%0b want=0", pix_out); end
        vectors++; if (pix_valid !== 1'b0)  begin miscompares++; $display("FAIL reset_pix_valid got=%0b want=0", pix_valid); end
        vectors++; if (fetch_err !== 1'b0)  begin miscompares++; $display("FAIL reset_fetch_err got=%0b want=0", fetch_err); end
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_first_tile();
        logic [7:0] pat;
        int valid_cnt;
        pat = 8'hA5;
        valid_cnt = 0;
        vram_mem[0] = 8'h05;
        rom_mem[9'h028] = 8'hA5;
        warm_line(255);
        for (int h = 0; h < 512; h++) begin
            tick(h, 0, 1'b0);
            if (pix_valid === 1'b1) valid_cnt++;
            if (h < 8) begin
                vectors++;
                if (pix_out !== pat[7-h]) begin miscompares++; $display("FAIL first_tile x=%0d got=%0b want=%0b", h, pix_out, pat[7-h]); end
            end else if (h < 256) begin
                vectors++;
                if (pix_out !== exp_pix(0, h)) begin miscompares++; $display("FAIL line0_pix x=%0d got=%0b want=%0b", h, pix_out, exp_pix(0, h)); end
            end
        end
        vectors++;
        if (valid_cnt != 256) begin miscompares++; $display("FAIL valid_count got=%0d want=256", valid_cnt); end
        $display("test_first_tile done");
    endtask

    task automatic test_last_column();
        logic [7:0] pat;
        pat = 8'h81;
        vram_mem[10'h0FF] = 8'h3F;
        rom_mem[9'h1FB] = 8'h81;
        warm_line(58);
        for (int h = 0; h < 512; h++) begin
            tick(h, 59, 1'b0);
            if (h >= 248 && h < 256) begin
                vectors++;
                if (pix_out !== pat[255-h]) begin miscompares++; $display("FAIL last_col_pix x=%0d got=%0b want=%0b", h, pix_out, pat[255-h]); end
                vectors++;
                if (vram_addr !== 10'h0FF) begin miscompares++; $display("FAIL no_fetch_248 h=%0d got=%0h want=0ff", h, vram_addr); end
            end
        end
        $display("test_last_column done");
    endtask

    task automatic test_vblank();
        logic [9:0] held;
        held = vram_addr;
        for (int h = 0; h < 512; h++) begin
            tick(h, 100, 1'b1);
            vectors++;
            if (vram_addr !== held) begin miscompares++; $display("FAIL vblank_addr h=%0d got=%0h want=%0h", h, vram_addr, held); end
            vectors++;
            if (pix_out !== 1'b0 || pix_valid !== 1'b0) begin
                miscompares++; $display("FAIL vblank_pix h=%0d got=%0b/%0b want=0/0", h, pix_out, pix_valid);
            end
        end
        $display("test_vblank done");
    endtask

    task automatic test_code_bit7();
        logic [7:0] pat;
`ifdef PF_INVERT_EN
        pat = 8'hA5 ^ 8'hFF;
`else
        pat = 8'hA5;
`endif
        vram_mem[0] = 8'h85;
        rom_mem[9'h028] = 8'hA5;
        warm_line(255);
        for (int h = 0; h < 256; h++) begin
            tick(h, 0, 1'b0);
            if (h < 8) begin
                vectors++;
                if (pix_out !== pat[7-h]) begin miscompares++; $display("FAIL code_bit7 x=%0d got=%0b want=%0b", h, pix_out, pat[7-h]); end
            end
        end
        for (int h = 256; h < 512; h++) tick(h, 0, 1'b0);
        $display("test_code_bit7 done");
    endtask

    task automatic test_fetch_abort();
        int errs;
        errs = 0;
        warm_line(36);
        for (int h = 0; h <= 18; h++) begin
            tick(h, 37, 1'b0);
            if (fetch_err === 1'b1) errs++;
            vectors++;
            if (pix_out !== exp_pix(37, h)) begin miscompares++; $display("FAIL abort_pre x=%0d got=%0b want=%0b", h, pix_out, exp_pix(37, h)); end
        end
        for (int h = 100; h < 512; h++) begin
            tick(h, 37, 1'b0);
            if (fetch_err === 1'b1) errs++;
            if (h == 100) begin
                vectors++;
                if (fetch_err !== 1'b1) begin miscompares++; $display("FAIL abort_pulse got=%0b want=1", fetch_err); end
            end
            if (h >= 104 && h < 112) begin
                vectors++;
                if (pix_out !== 1'b0) begin miscompares++; $display("FAIL abort_blank x=%0d got=%0b want=0", h, pix_out); end
            end else if (h >= 112 && h < 256) begin
                vectors++;
                if (pix_out !== exp_pix(37, h)) begin miscompares++; $display("FAIL abort_post x=%0d got=%0b want=%0b", h, pix_out, exp_pix(37, h)); end
            end
        end
        vectors++;
        if (errs != 1) begin miscompares++; $display("FAIL abort_count got=%0d want=1", errs); end
        $display("test_fetch_abort done");
    endtask

    task automatic test_reset_mid_fetch();
        warm_line(79);
        for (int h = 0; h < 3; h++) tick(h, 80, 1'b0);
        hcount = 9'd3;
        reset  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            vectors++;
            if (vram_addr !== 10'd0 || rom_addr !== 9'd0 || pix_out !== 1'b0 ||
                pix_valid !== 1'b0 || fetch_err !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_mid k=%0d got=%0h/%0h/%0b/%0b/%0b want=0/0/0/0/0",
                         k, vram_addr, rom_addr, pix_out, pix_valid, fetch_err);
            end
            tick(3 + k, 80, 1'b0);
        end
        reset = 1'b0;
        for (int h = 5; h < 512; h++) begin
            tick(h, 80, 1'b0);
            if (h < 16) begin
                vectors++;
                if (pix_out !== 1'b0) begin miscompares++; $display("FAIL reset_gap x=%0d got=%0b want=0", h, pix_out); end
            end else if (h < 256) begin
                vectors++;
                if (pix_out !== exp_pix(80, h)) begin miscompares++; $display("FAIL reset_resume x=%0d got=%0b want=%0b", h, pix_out, exp_pix(80, h)); end
            end
        end
        $display("test_reset_mid_fetch done");
    endtask

    task automatic test_random_lines();
        int v0, v;
        for (int rep = 0; rep < 3; rep++) begin
            randomize_mem();
            v0 = $urandom_range(0, 255);
            warm_line((v0 + 255) % 256);
            for (int l = 0; l < 6; l++) begin
                v = (v0 + l) % 256;
                for (int h = 0; h < 512; h++) begin
                    tick(h, v, 1'b0);
                    vectors++;
                    if (fetch_err !== 1'b0) begin miscompares++; $display("FAIL rand_err v=%0d h=%0d got=%0b want=0", v, h, fetch_err); end
                    vectors++;
                    if (pix_valid !== (h < 256)) begin miscompares++; $display("FAIL rand_valid v=%0d h=%0d got=%0b want=%0b", v, h, pix_valid, (h < 256)); end
                    if (h < 256) begin
                        vectors++;
                        if (pix_out !== exp_pix(v, h)) begin miscompares++; $display("FAIL rand_pix v=%0d x=%0d got=%0b want=%0b", v, h, pix_out, exp_pix(v, h)); end
                    end else begin
                        vectors++;
                        if (pix_out !== 1'b0) begin miscompares++; $display("FAIL rand_blank v=%0d h=%0d got=%0b want=0", v, h, pix_out); end
                    end
                end
            end
            $display("test_random_lines rep=%0d start_line=%0d done", rep, v0);
        end
    endtask

    initial begin
        reset  = 1'b1;
        hcount = 9'd0;
        vcount = 8'd0;
        vblank = 1'b0;
        randomize_mem();
        test_reset();
        test_first_tile();
        test_last_column();
        test_vblank();
        test_code_bit7();
        test_fetch_abort();
        test_reset_mid_fetch();
        test_random_lines();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
